mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Round-robin arbiter that shares one 2:1 3-bit data multiplexer between two requesters. Each requester presents a valid/data/last burst interface. The arbiter grants ownership per burst, drives the mux `select`, and registers the selected beat into a single output stage with valid/ready backpressure. It sits in front of the shared datapath mux in the IPU and is the only agent allowed to drive its select line.

## Interface
- `DW`, default 3: data width of each requester and of the output.
- `MAX_BURST`, default 8: maximum beats accepted per grant. Must be ≥1. Beat counter width is `$clog2(MAX_BURST+1)`.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0` / `req1`  in  1  requester k has a valid beat.
- `data0` / `data1`  in  DW  beat data from requester k.
- `last0` / `last1`  in  1  beat is the last of requester k's burst.
- `ack0` / `ack1`  out  1  combinational; beat from requester k accepted this cycle.
- `select`  out  1  registered mux select: 0 = requester 0, 1 = requester 1.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  DW  registered beat.
- `out_src`  out  1  source index of `out_data`.
- `out_ready`  in  1  downstream accepts the `out_data` beat.

## Operation
- State machine states: IDLE, OWN0, OWN1. Registers `prio` (1 bit; requester that wins a tie), `cnt` (beats accepted in the current grant), and the output stage.
- `select` = 1 only in OWN1, 0 in IDLE and OWN0.
- IDLE transitions:
  - neither request → stay in IDLE;
  - only `req_k` → OWNk;
  - both → OWN`prio`.
- Slot free: `slot = !out_valid || out_ready`.
- In OWNk, `ack_k = req_k && slot`. The other ack is always 0. Both acks are 0 in IDLE.
- On an accepted beat:
  - `out_data` ← `data_k`;
  - `out_src` ← k;
  - `out_valid` ← 1;
  - `cnt` ← `cnt`+1.
- If `out_valid && out_ready` with no accepted beat, `out_valid` ← 0. `out_data` and `out_src` hold their values.
- Release occurs on an accepted beat with `last_k`=1, or when the accepted beat makes `cnt`+1 == `MAX_BURST`. On release:
  - `prio` ← !k;
  - `cnt` ← 0;
  - next state: OWN(!k) if `req_(!k)`, else OWNk if `req_k`, else IDLE.
- No release while the owner idles (`req_k`=0, `last_k` not yet seen). Ownership is held and the other requester waits.
- `last_k` is ignored when `ack_k`=0.
- `cnt` never exceeds `MAX_BURST`−1 between beats. With `MAX_BURST`=1, every accepted beat releases.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state IDLE, `prio` 0, `cnt` 0;
  - `select` 0, `out_valid` 0, `out_data` 0, `out_src` 0;
  - `ack0` = `ack1` = 0.
- Request-to-output latency from IDLE:
  - request seen in cycle N;
  - OWNk and `select` valid in N+1, with `ack_k` in N+1 if the slot is free;
  - `out_valid` in N+2.
- Steady-state burst throughput is one beat per cycle while `out_ready`=1.
- Ownership handover to a waiting requester costs no idle cycle. The first beat of the new owner is accepted in the cycle after the releasing beat.
- Backpressure: `out_valid`=1 and `out_ready`=0 forces `ack`=0. `out_data`, `out_src` and `out_valid` stay stable until the `out_ready`=1 cycle, in which a new beat may load simultaneously.
- Reset asserted mid-burst aborts the burst; no partial state survives. After `rst_n` deasserts, the first arbitration uses `prio`=0.

## Test plan
- Reset:
  - stimulus: hold `rst_n`=0 with random inputs;
  - response: `select`, `out_valid`, `out_data`, `out_src`, `ack0`, `ack1` all 0.
- Single-burst timing:
  - stimulus: after reset, `req0` with beats 3'b001, 3'b010, 3'b011 (`last0` on the third), `out_ready`=1;
  - response: `ack0` high cycles 1-3, `out_data` 001/010/011 in cycles 2-4, `out_src`=0, `select`=0, state back to IDLE in cycle 4.
- Alternation:
  - stimulus: `req0` and `req1` held high from reset, `last0` = `last1` = 1, `data0`=3'b101, `data1`=3'b110;
  - response: `out_data` alternates 101, 110, 101… every cycle; `select` and `out_src` toggle; first beat from requester 0.
- Burst cap:
  - stimulus: `MAX_BURST`=8, `req0` continuous with `last0`=0, `req1` high;
  - response: exactly 8 `ack0` pulses, then OWN1 the next cycle with `ack1`.
- Backpressure:
  - stimulus: `out_ready`=0 for 4 cycles while `out_valid`=1 and `req0` high;
  - response: `ack0`=0 and `out_data` stable throughout; first `out_ready`=1 cycle loads the next beat, `ack0`=1.
- Mid-burst reset:
  - stimulus: `rst_n` pulsed low during the 2nd beat of a `req1` burst while `req0` is also high;
  - response: outputs 0 within the same cycle; after release requester 0 wins (`select`=0).

Source files
------------

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for two valid/data/last burst requesters that share one
// 2:1 data mux. Grants are held per burst and the chosen beat lands in a
// single registered output stage with valid/ready backpressure.
module mux_arbiter #(
  parameter int DW        = 3,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  input  logic          last0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  input  logic          last1,
  output logic          ack0,
  output logic          ack1,
  output logic          select,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_src,
  input  logic          out_ready
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          prio, prio_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic          slot;
  logic          accept;
  logic          own_idx;
  logic          own_last;
  logic          own_req;
  logic          other_req;
  logic          rel;
  logic [DW-1:0] own_data;

  assign slot      = !out_valid || out_ready;
  assign own_idx   = (state == OWN1);
  assign own_data  = own_idx ? data1 : data0;
  assign own_last  = own_idx ? last1 : last0;
  assign own_req   = own_idx ? req1 : req0;
  assign other_req = own_idx ? req0 : req1;

  assign ack0   = (state == OWN0) && req0 && slot;
  assign ack1   = (state == OWN1) && req1 && slot;
  assign accept = ack0 || ack1;

  assign cnt_inc = cnt + CW'(1);
  // The burst cap releases on the beat that would bring the count to MAX_BURST,
  // so cnt itself never holds more than MAX_BURST-1 between beats.
  assign rel = accept && (own_last || (cnt_inc == CW'(MAX_BURST)));

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = prio ? OWN1 : OWN0;
        end else if (req0) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (rel) begin
          prio_nxt = !own_idx;
          cnt_nxt  = '0;
          if (other_req) begin
            state_nxt = own_idx ? OWN0 : OWN1;
          end else if (own_req) begin
            state_nxt = state;
          end else begin
            state_nxt = IDLE;
          end
        end else if (accept) begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      prio   <= 1'b0;
      cnt    <= '0;
      select <= 1'b0;
    end else begin
      state  <= state_nxt;
      prio   <= prio_nxt;
      cnt    <= cnt_nxt;
      select <= (state_nxt == OWN1);
    end
  end

  // Output stage: a fresh beat may load in the same cycle the held one drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= own_data;
      out_src   <= own_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Randomized bench for mux_arbiter: a burst-level reference model predicts
// acks/select and queues accepted beats; a monitor checks the output stage.
module tb_mux_arbiter;

  localparam int DW        = 3;
  localparam int MAX_BURST = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          last0 = 1'b0, last1 = 1'b0;
  logic          out_ready = 1'b0;
  logic          ack0, ack1, select, out_valid, out_src;
  logic [DW-1:0] out_data;

  mux_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .last0(last0),
    .req1(req1), .data1(data1), .last1(last1),
    .ack0(ack0), .ack1(ack1), .select(select),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the mux, who wins the next tie, beats in this grant.
  int m_owner = -1;
  int m_prio  = 0;
  int m_beats = 0;
  bit m_valid = 1'b0;
  logic [DW:0] sb[$];
  logic [DW:0] mon_exp;
  logic obs_ack0, obs_ack1;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_beats = 0;
    m_valid = 1'b0;
    sb.delete();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_select"}, int'(select), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_out_src"}, int'(out_src), 0);
    chk({tag, "_ack0"}, int'(ack0), 0);
    chk({tag, "_ack1"}, int'(ack1), 0);
  endtask

  task automatic drive_random();
    req0      = 1'($urandom);
    req1      = 1'($urandom);
    data0     = DW'($urandom);
    data1     = DW'($urandom);
    last0     = 1'($urandom);
    last1     = 1'($urandom);
    out_ready = 1'($urandom);
  endtask

  task automatic step(input logic r0, input logic r1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic l0, input logic l1, input logic rdy);
    bit slot_m;
    bit ea0, ea1;
    int k;
    @(posedge clk);
    #1;
    req0 = r0; req1 = r1; data0 = d0; data1 = d1;
    last0 = l0; last1 = l1; out_ready = rdy;
    #1;
    slot_m = !m_valid || rdy;
    ea0 = (m_owner == 0) && r0 && slot_m;
    ea1 = (m_owner == 1) && r1 && slot_m;
    obs_ack0 = ack0;
    obs_ack1 = ack1;
    chk("ack0", int'(ack0), int'(ea0));
    chk("ack1", int'(ack1), int'(ea1));
    chk("select", int'(select), (m_owner == 1) ? 1 : 0);
    chk("out_valid", int'(out_valid), int'(m_valid));
    if (m_owner < 0) begin
      if (r0 && r1) m_owner = m_prio;
      else if (r0) m_owner = 0;
      else if (r1) m_owner = 1;
    end else if (ea0 || ea1) begin
      k = m_owner;
      sb.push_back({k[0], (k == 1) ? d1 : d0});
      m_beats++;
      if (((k == 1) ? l1 : l0) || m_beats == MAX_BURST) begin
        m_prio  = 1 - k;
        m_beats = 0;
        if ((k == 1) ? r0 : r1) m_owner = 1 - k;
        else if ((k == 1) ? r1 : r0) m_owner = k;
        else m_owner = -1;
      end
    end
    if (ea0 || ea1) m_valid = 1'b1;
    else if (rdy) m_valid = 1'b0;
  endtask

  // Pulls reset low mid-cycle, holds it, then releases with quiet inputs.
  task automatic reset_pulse(int low_cycles);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    model_reset();
    for (int i = 0; i < low_cycles; i++) begin
      @(posedge clk);
      #1;
      drive_random();
      #1;
      chk_zero("rst_hold");
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL out_beat: got src %0d data %0d expected no beat", out_src, out_data);
      end else begin
        mon_exp = sb.pop_front();
        chk("out_beat", int'({out_src, out_data}), int'(mon_exp));
      end
    end
  end

  initial begin
    int n0, cap_count;
    bit seen1;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      #2;
      drive_random();
      #1;
      chk_zero("reset");
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;

    // Single three-beat burst from requester 0
    step(1, 0, 3'b001, 0, 0, 0, 1);
    step(1, 0, 3'b001, 0, 0, 0, 1);
    step(1, 0, 3'b010, 0, 0, 0, 1);
    step(1, 0, 3'b011, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);

    // Alternation with single-beat bursts
    reset_pulse(1);
    for (int i = 0; i < 10; i++) step(1, 1, 3'b101, 3'b110, 1, 1, 1);

    // Burst cap while requester 1 waits
    reset_pulse(1);
    cap_count = 0;
    seen1 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(1, 1, DW'(i), DW'(7 - i), 0, 0, 1);
      if (obs_ack1) seen1 = 1'b1;
      if (obs_ack0 && !seen1) cap_count++;
    end
    chk("burst_cap_acks", cap_count, MAX_BURST);
    chk("burst_cap_handover", int'(seen1), 1);

    // Backpressure holds the output stage
    reset_pulse(1);
    step(1, 0, 3'd5, 0, 0, 0, 1);
    step(1, 0, 3'd5, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 3'd6, 0, 0, 0, 0);
      chk("bp_hold_data", int'(out_data), 5);
    end
    step(1, 0, 3'd6, 0, 1, 0, 1);
    chk("bp_release_ack", int'(obs_ack0), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);

    // Reset in the middle of a requester-1 burst, then requester 0 wins
    reset_pulse(1);
    step(0, 1, 0, 3'd1, 0, 0, 1);
    step(0, 1, 0, 3'd1, 0, 0, 1);
    step(1, 1, 3'd4, 3'd2, 0, 0, 1);
    reset_pulse(1);
    step(1, 1, 3'd4, 3'd3, 0, 0, 1);
    step(1, 1, 3'd4, 3'd3, 0, 0, 1);
    chk("post_reset_select", int'(select), 0);
    step(1, 1, 3'd4, 3'd3, 1, 0, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset_pulse(int'($urandom_range(0, 2)));
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
             DW'($urandom), DW'($urandom),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 3) != 0));
      end
    end

    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
